// File: rtl/rcb_frl_msg_tx_framer.sv
// Fast Radio Link message-channel transmit framer: buffers upstream words and emits
// training bursts, idle fill and SYNC/payload/checksum frames, one word per clock.
module rcb_frl_msg_tx_framer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MSG_LEN    = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TRAIN_LEN  = 64,
   parameter logic [DATA_WIDTH-1:0] TRAIN_WORD = 8'h5C,
   parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 8'hF5,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 8'h5F
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          train_req,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          oce,
   output logic                          busy,
   output logic                          training,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned DW   = DATA_WIDTH;
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned CMAX = (TRAIN_LEN > FIFO_DEPTH) ? TRAIN_LEN : FIFO_DEPTH;
   localparam int unsigned CW   = $clog2(CMAX) + 1;

   localparam logic [2:0] ST_TRAIN = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_SYNC  = 3'd2;
   localparam logic [2:0] ST_PAY   = 3'd3;
   localparam logic [2:0] ST_CSUM  = 3'd4;

   // state names the word that goes onto dout at the next edge
   logic [2:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pending, pending_nxt;
   logic [DW-1:0] acc, acc_nxt;
   logic [DW-1:0] dout_nxt;
   logic          pop, push;
   logic [LW-1:0] level_nxt;

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign push = in_valid && in_ready;

   // next-state, next-word and checksum accumulation
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      acc_nxt     = acc;
      dout_nxt    = IDLE_WORD;
      pop         = 1'b0;
      case (state)
         ST_TRAIN: begin
            dout_nxt = TRAIN_WORD;
            if (cnt == CW'(TRAIN_LEN - 1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_IDLE: begin
            dout_nxt = IDLE_WORD;
            if (pending)                         state_nxt = ST_TRAIN;
            else if (fifo_level >= LW'(MSG_LEN)) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            dout_nxt  = SYNC_WORD;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_PAY;
         end
         ST_PAY: begin
            dout_nxt = mem[rd_ptr];
            pop      = 1'b1;
            acc_nxt  = acc + mem[rd_ptr];
            if (cnt == CW'(MSG_LEN - 1)) begin
               state_nxt = ST_CSUM;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_CSUM: begin
            dout_nxt = ~acc + DW'(1);
            if (pending)                         state_nxt = ST_TRAIN;
            else if (fifo_level >= LW'(MSG_LEN)) state_nxt = ST_SYNC;
            else                                 state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_TRAIN;
            cnt_nxt   = '0;
         end
      endcase
      if (state_nxt == ST_TRAIN && state != ST_TRAIN) pending_nxt = 1'b0;
      else if (train_req && state != ST_TRAIN)        pending_nxt = 1'b1;
   end

   // occupancy after this cycle's push/pop
   always_comb begin
      level_nxt = fifo_level;
      if (push && !pop)      level_nxt = fifo_level + LW'(1);
      else if (!push && pop) level_nxt = fifo_level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_TRAIN;
         cnt        <= '0;
         pending    <= 1'b0;
         acc        <= '0;
         dout       <= '0;
         oce        <= 1'b0;
         busy       <= 1'b0;
         training   <= 1'b0;
         frame_done <= 1'b0;
         in_ready   <= 1'b0;
         fifo_level <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pending    <= pending_nxt;
         acc        <= acc_nxt;
         dout       <= dout_nxt;
         oce        <= 1'b1;
         busy       <= (state == ST_SYNC) || (state == ST_PAY) || (state == ST_CSUM);
         training   <= (state == ST_TRAIN);
         frame_done <= (state == ST_CSUM);
         in_ready   <= (level_nxt < LW'(FIFO_DEPTH));
         fifo_level <= level_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // storage needs no reset; the pointers define validity
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_rcb_frl_msg_tx_framer.sv
// Randomized bench for rcb_frl_msg_tx_framer: a word-plan reference model predicts
// every output word, status flag and FIFO occupancy cycle by cycle.
module tb_rcb_frl_msg_tx_framer;

   localparam int unsigned DW    = 8;
   localparam int unsigned MLEN  = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TLEN  = 16;

   localparam int K_TRN = 0;
   localparam int K_IDL = 1;
   localparam int K_SYN = 2;
   localparam int K_PAY = 3;
   localparam int K_CS  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          train_req;
   logic [DW-1:0] dout;
   logic          oce, busy, training, frame_done;
   logic [4:0]    fifo_level;

   rcb_frl_msg_tx_framer #(
      .DATA_WIDTH(DW), .MSG_LEN(MLEN), .FIFO_DEPTH(DEPTH), .TRAIN_LEN(TLEN),
      .TRAIN_WORD(8'h5C), .SYNC_WORD(8'hF5), .IDLE_WORD(8'h5F)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .train_req(train_req), .dout(dout), .oce(oce), .busy(busy), .training(training),
      .frame_done(frame_done), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] w;
      int         k;
   } ent_t;

   // model: a plan of upcoming wire words plus the buffered payload
   ent_t       plan[$];
   logic [7:0] mfifo[$];
   bit         mpend;
   logic [7:0] e_dout;
   bit         e_oce, e_busy, e_trn, e_fd, e_rdy;
   int         e_lvl;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic plan_push(input logic [7:0] w, input int k);
      ent_t e;
      e.w = w;
      e.k = k;
      plan.push_back(e);
   endtask

   task automatic plan_train();
      for (int i = 0; i < int'(TLEN); i++) plan_push(8'h5C, K_TRN);
   endtask

   task automatic plan_frame();
      logic [7:0] sum;
      sum = 8'h00;
      plan_push(8'hF5, K_SYN);
      for (int i = 0; i < int'(MLEN); i++) begin
         plan_push(mfifo[i], K_PAY);
         sum = sum + mfifo[i];
      end
      plan_push(8'h00 - sum, K_CS);
   endtask

   task automatic m_reset();
      plan.delete();
      mfifo.delete();
      mpend = 1'b0;
      plan_train();
      e_dout = 8'h00; e_oce = 1'b0; e_busy = 1'b0; e_trn = 1'b0;
      e_fd = 1'b0; e_rdy = 1'b0; e_lvl = 0;
   endtask

   task automatic m_step(input bit v, input logic [7:0] d, input bit req, output bit acc);
      ent_t e;
      bit   rdy;
      bit   entering;
      int   lvl0;
      lvl0     = mfifo.size();
      rdy      = e_rdy;
      entering = 1'b0;
      e        = plan.pop_front();
      if (plan.size() == 0) begin
         if (e.k == K_TRN) plan_push(8'h5F, K_IDL);
         else if (mpend) begin
            plan_train();
            entering = 1'b1;
         end else if (lvl0 >= int'(MLEN)) plan_frame();
         else if (e.k == K_CS || e.k == K_IDL) plan_push(8'h5F, K_IDL);
      end
      if (entering)                 mpend = 1'b0;
      else if (req && e.k != K_TRN) mpend = 1'b1;
      if (e.k == K_PAY) void'(mfifo.pop_front());
      acc = v && rdy;
      if (acc) mfifo.push_back(d);
      e_dout = e.w;
      e_oce  = 1'b1;
      e_trn  = (e.k == K_TRN);
      e_busy = (e.k == K_SYN) || (e.k == K_PAY) || (e.k == K_CS);
      e_fd   = (e.k == K_CS);
      e_lvl  = mfifo.size();
      e_rdy  = (mfifo.size() < int'(DEPTH));
   endtask

   task automatic check_all();
      chk("dout",       32'(dout),       32'(e_dout));
      chk("oce",        32'(oce),        32'(e_oce));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("training",   32'(training),   32'(e_trn));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("fifo_level", 32'(fifo_level), 32'(e_lvl));
      chk("in_ready",   32'(in_ready),   32'(e_rdy));
   endtask

   initial begin
      bit acc;
      bit forced;
      int mode;
      forced    = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      train_req = 1'b0;
      m_reset();
      repeat (3) begin
         @(posedge clk);
         #1;
         check_all();
      end
      rst     = 1'b0;
      in_data = 8'($urandom);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         mode = (cyc / 250) % 4;
         if (cyc < 40)       in_valid = 1'b1;
         else if (mode == 0) in_valid = 1'b1;
         else if (mode == 1) in_valid = ($urandom_range(0, 1) == 0);
         else if (mode == 2) in_valid = ($urandom_range(0, 9) == 0);
         else                in_valid = ($urandom_range(0, 3) == 0);
         train_req = (cyc > 60) && ($urandom_range(0, 49) == 0);
         rst = (cyc > 100) && ($urandom_range(0, 499) == 0);
         if (!forced && cyc > 300 && plan.size() > 0 && plan[0].k == K_PAY) begin
            rst    = 1'b1;
            forced = 1'b1;
         end
         @(posedge clk);
         acc = 1'b0;
         if (rst) m_reset();
         else     m_step(in_valid, in_data, train_req, acc);
         #1;
         check_all();
         if (acc) in_data = 8'($urandom);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rcb_frl_msg_tx_framer.md
Name: rcb_frl_msg_tx_framer

Overview:
Parametrised message-channel transmit framer for the Fast Radio Link. It runs in the divided (parallel) clock domain and produces one DATA_WIDTH-bit word per cycle for the downstream OSERDES serializer. Upstream data words are buffered in an internal FIFO. The framer emits a link-training pattern after reset or on request, idle fill between frames, and SYNC-delimited fixed-length frames closed by a checksum word.

Parameters:
DATA_WIDTH, 8, width of the parallel word handed to the serializer and of the upstream data.
MSG_LEN, 8, number of payload words per frame (2..FIFO_DEPTH).
FIFO_DEPTH, 16, input FIFO depth in words; power of 2, at least MSG_LEN.
TRAIN_LEN, 64, number of training words sent per training burst (1..1024).
TRAIN_WORD, 8'h5C, training pattern that the receiver uses for bitslip alignment.
SYNC_WORD, 8'hF5, frame start delimiter.
IDLE_WORD, 8'h5F, fill word sent between frames.

Ports:
clk  in  1  parallel-word clock (divided serializer clock); the only clock
rst  in  1  synchronous reset, active-high
in_data  in  DATA_WIDTH  upstream payload word
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a word
train_req  in  1  request a training burst (pulse or level)
dout  out  DATA_WIDTH  word to the serializer D inputs, MSB sent first
oce  out  1  serializer output clock enable
busy  out  1  high in SYNC, PAYLOAD and CSUM states
training  out  1  high in TRAIN state
frame_done  out  1  one-cycle pulse in the CSUM cycle
fifo_level  out  clog2(FIFO_DEPTH)+1  registered FIFO occupancy

Behaviour:
- All outputs are registered. Reset values: dout=0, oce=0, in_ready=0, busy=0, training=0, frame_done=0, fifo_level=0. The state goes to TRAIN, counters clear and the FIFO is flushed.
- oce goes to 1 on the first cycle after rst deasserts and stays at 1. in_ready follows the same timing and thereafter equals (fifo_level < FIFO_DEPTH).
- FIFO push happens on in_valid && in_ready. Pop happens only in PAYLOAD. Push and pop in the same cycle leave fifo_level unchanged. A push with in_ready=0 is dropped; the source must hold its word.
- dout in each state:
  - TRAIN: TRAIN_WORD
  - IDLE: IDLE_WORD
  - SYNC: SYNC_WORD
  - PAYLOAD: the popped FIFO word
  - CSUM: the checksum word
- State transitions are evaluated on the registered fifo_level and on pending_train:
  - TRAIN -> IDLE after exactly TRAIN_LEN cycles in TRAIN.
  - IDLE -> TRAIN if pending_train; else IDLE -> SYNC if fifo_level >= MSG_LEN; else stay in IDLE.
  - SYNC -> PAYLOAD after 1 cycle.
  - PAYLOAD -> CSUM after exactly MSG_LEN cycles. One word is popped per cycle, and the FIFO never underflows because entry required a full message to be buffered.
  - CSUM -> TRAIN if pending_train; else CSUM -> SYNC if fifo_level >= MSG_LEN (back-to-back frames, no idle gap); else CSUM -> IDLE.
- Checksum: sum of the payload words mod 2^DATA_WIDTH; the CSUM word is its two's complement. The sum of all payload words plus CSUM is therefore 0 mod 2^DATA_WIDTH. The accumulator clears on SYNC.
- train_req: any cycle with train_req=1 outside TRAIN sets pending_train. pending_train clears on entering TRAIN. train_req while in TRAIN is ignored and does not restart the burst. A request raised mid-frame never truncates the frame; training starts after CSUM.
- The frame length on the wire is always MSG_LEN+2 words.
- rst asserted mid-frame aborts immediately: buffered data is lost, and after release the framer re-trains for TRAIN_LEN words.
- busy and training are decoded from the registered state and are aligned with dout.

Test Plan:
- Reset release, DATA_WIDTH=8, TRAIN_LEN=16 -> oce=1 from cycle 1; dout=5C for 16 cycles, then 5F continuously; training high for exactly 16 cycles.
- MSG_LEN=4, push 01,02,03,04 after training -> dout sequence F5,01,02,03,04,F6,5F; frame_done high only on the F6 cycle; fifo_level returns to 0.
- Push 8 words with MSG_LEN=4 before a frame starts -> two back-to-back frames F5,w0..w3,cs0,F5,w4..w7,cs1 with no 5F between them.
- Hold in_valid=1 with payload stalled in TRAIN, FIFO_DEPTH=16 -> in_ready drops when fifo_level=16; the 17th word is held, not lost, and is sent in a later frame.
- Pulse train_req during the 2nd payload word -> the frame completes with a correct CSUM, then 16 cycles of 5C, then IDLE or the next frame; a second pulse during TRAIN does not lengthen the burst.
- Assert rst during PAYLOAD -> the next cycle has dout=0, oce=0, fifo_level=0; after release the training burst repeats and no stale payload appears.
